// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the ROWS x COLS matrix-vector engine: memory fetch, FIFO unpack, systolic MAC drain.
// Optional busy-cycle counter output enabled by defining MATMUL_SEQ_CTRL_PERF_EN.
module matmul_seq_ctrl #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [ADDR_W-1:0]      i_base_addr,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic [ADDR_W-1:0]      o_mem_addr,
    output logic                   o_mem_read,
    input  logic                   i_mem_waitrequest,
    input  logic                   i_mem_readdatavalid,
    input  logic [COLS*DATA_W-1:0] i_mem_readdata,
    output logic [ROWS:0]          o_fifo_wrreq,
    output logic [DATA_W-1:0]      o_fifo_wdata,
    input  logic [ROWS:0]          i_fifo_wrfull,
    output logic [ROWS:0]          o_fifo_rdreq,
    input  logic [ROWS:0]          i_fifo_rdempty,
    output logic                   o_mac_clr,
    output logic [ROWS-1:0]        o_mac_en
`ifdef MATMUL_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]            o_perf_cycles
`endif
);

    localparam int K_W = $clog2(ROWS + 1);
    localparam int B_W = $clog2(COLS);
    localparam int T_W = $clog2(ROWS + COLS);

    localparam logic [K_W-1:0] K_LAST = K_W'(ROWS);
    localparam logic [B_W-1:0] B_LAST = B_W'(COLS - 1);
    localparam logic [T_W-1:0] T_LAST = T_W'(ROWS + COLS - 2);
    localparam logic [ROWS:0]  ONE    = {{ROWS{1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_UNPACK = 3'd3;
    localparam logic [2:0] S_CLR    = 3'd4;
    localparam logic [2:0] S_EXEC   = 3'd5;
    localparam logic [2:0] S_FLUSH  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]             r_state;
    logic [K_W-1:0]         r_k;
    logic [B_W-1:0]         r_byte;
    logic [T_W-1:0]         r_t;
    logic [COLS*DATA_W-1:0] r_word;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic                   r_mem_read;
    logic [ROWS:0]          r_fifo_wrreq;
    logic [DATA_W-1:0]      r_fifo_wdata;
    logic [ROWS:0]          r_fifo_rdreq;
    logic                   r_mac_clr;
    logic [ROWS-1:0]        r_mac_en;
    logic                   w_underrun;

    // Read strobes for stagger step t: B for the first COLS steps, row i delayed by i steps.
    function automatic logic [ROWS:0] f_rd_pat(input logic [T_W-1:0] t);
        logic [ROWS:0] p;
        int            tv;
        tv      = int'(t);
        p       = '0;
        p[ROWS] = (tv < COLS);
        for (int i = 0; i < ROWS; i++) p[i] = (tv >= i) && (tv < i + COLS);
        return p;
    endfunction

    assign w_underrun = |(r_fifo_rdreq & i_fifo_rdempty);

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_byte       <= '0;
            r_t          <= '0;
            r_word       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_read   <= 1'b0;
            r_fifo_wrreq <= '0;
            r_fifo_wdata <= '0;
            r_fifo_rdreq <= '0;
            r_mac_clr    <= 1'b0;
            r_mac_en     <= '0;
        end else begin
            r_done       <= 1'b0;
            r_mac_clr    <= 1'b0;
            r_fifo_wrreq <= '0;
            // FIFO data appears one cycle after the strobe, so the MAC enable trails it.
            r_mac_en     <= r_fifo_rdreq[ROWS-1:0];
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_REQ;
                        r_busy     <= 1'b1;
                        r_err      <= 1'b0;
                        r_k        <= '0;
                        r_mem_addr <= i_base_addr;
                        r_mem_read <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (!i_mem_waitrequest) begin
                        r_mem_read <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_mem_readdatavalid) begin
                        r_word  <= i_mem_readdata;
                        r_byte  <= '0;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    if (!i_fifo_wrfull[r_k]) begin
                        r_fifo_wrreq <= ONE << r_k;
                        r_fifo_wdata <= r_word[DATA_W-1:0];
                        r_word       <= r_word >> DATA_W;
                        r_byte       <= r_byte + 1'b1;
                        if (r_byte == B_LAST) begin
                            if (r_k == K_LAST) begin
                                r_state   <= S_CLR;
                                r_mac_clr <= 1'b1;
                            end else begin
                                r_k        <= r_k + 1'b1;
                                r_mem_addr <= r_mem_addr + 1'b1;
                                r_mem_read <= 1'b1;
                                r_state    <= S_REQ;
                            end
                        end
                    end
                end
                S_CLR: begin
                    r_state      <= S_EXEC;
                    r_t          <= '0;
                    r_fifo_rdreq <= f_rd_pat('0);
                end
                S_EXEC: begin
                    if (w_underrun) begin
                        r_err        <= 1'b1;
                        r_fifo_rdreq <= '0;
                        r_mac_en     <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (r_t == T_LAST) begin
                        r_fifo_rdreq <= '0;
                        r_state      <= S_FLUSH;
                    end else begin
                        r_t          <= r_t + 1'b1;
                        r_fifo_rdreq <= f_rd_pat(r_t + 1'b1);
                    end
                end
                S_FLUSH: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_read   = r_mem_read;
    assign o_fifo_wrreq = r_fifo_wrreq;
    assign o_fifo_wdata = r_fifo_wdata;
    assign o_fifo_rdreq = r_fifo_rdreq;
    assign o_mac_clr    = r_mac_clr;
    assign o_mac_en     = r_mac_en;

`ifdef MATMUL_SEQ_CTRL_PERF_EN
    logic [31:0] r_perf;

    // Counts every active cycle up to the one that raises done; the DONE cycle itself is excluded.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            r_perf <= '0;
        end else if (r_state == S_IDLE) begin
            if (i_start) r_perf <= '0;
        end else if (r_state != S_DONE && r_perf != 32'hFFFF_FFFF) begin
            r_perf <= r_perf + 1'b1;
        end
    end

    assign o_perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: memory, FIFO and MAC models with a write scoreboard and directed jobs.
`timescale 1ns/1ps
module tb_matmul_seq_ctrl;
    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 32;

    logic                   clk = 1'b0;
    logic                   i_rst_n, i_start;
    logic [ADDR_W-1:0]      i_base_addr;
    logic                   o_busy, o_done, o_err;
    logic [ADDR_W-1:0]      o_mem_addr;
    logic                   o_mem_read;
    logic                   i_mem_waitrequest, i_mem_readdatavalid;
    logic [COLS*DATA_W-1:0] i_mem_readdata;
    logic [ROWS:0]          o_fifo_wrreq, i_fifo_wrfull, o_fifo_rdreq, i_fifo_rdempty;
    logic [DATA_W-1:0]      o_fifo_wdata;
    logic                   o_mac_clr;
    logic [ROWS-1:0]        o_mac_en;
`ifdef MATMUL_SEQ_CTRL_PERF_EN
    logic [31:0]            o_perf_cycles;
`endif

    always #5 clk = ~clk;

    matmul_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_mem_addr(o_mem_addr), .o_mem_read(o_mem_read),
        .i_mem_waitrequest(i_mem_waitrequest), .i_mem_readdatavalid(i_mem_readdatavalid),
        .i_mem_readdata(i_mem_readdata),
        .o_fifo_wrreq(o_fifo_wrreq), .o_fifo_wdata(o_fifo_wdata), .i_fifo_wrfull(i_fifo_wrfull),
        .o_fifo_rdreq(o_fifo_rdreq), .i_fifo_rdempty(i_fifo_rdempty),
        .o_mac_clr(o_mac_clr), .o_mac_en(o_mac_en)
`ifdef MATMUL_SEQ_CTRL_PERF_EN
        , .o_perf_cycles(o_perf_cycles)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [ROWS:0] v);
        int r;
        r = -1;
        for (int j = 0; j <= ROWS; j++) if (v[j]) r = j;
        return r;
    endfunction

    // Controls owned by the stimulus process
    logic [ADDR_W-1:0] cur_base    = '0;
    logic [ADDR_W-1:0] stall_addr  = '1;
    int                stall_n     = 0;
    bit                full_en     = 1'b0;
    logic [ROWS:0]     force_empty = '0;

    // Model state owned by the negedge process
    logic [COLS*DATA_W-1:0] mem_word;
    logic [15:0]            exp_wr[$];
    logic [DATA_W-1:0]      fq[0:ROWS][$];
    logic [DATA_W-1:0]      rd_data[0:ROWS];
    int                     b_vals[$];
    int                     acc[ROWS], en_cnt[ROWS], first_en[ROWS], last_en[ROWS];
    int                     wr_cnt[ROWS+1], rd_cnt[ROWS+1];
    int                     gcyc = 0, b_first = -1, done_cnt = 0;
    int                     stall_used = 0, full_left = 0;
    bit                     full_fired = 0, full_prev = 0, stall_prev = 0, acc_pend = 0;
    logic [ADDR_W-1:0]      acc_addr;
    logic [ROWS:0]          empty_now;
    logic [15:0]            e;

    always @(negedge clk) begin
        gcyc++;
        if (i_rst_n) begin
            exp_wr.delete();
            b_vals.delete();
            for (int j = 0; j <= ROWS; j++) begin fq[j].delete(); rd_data[j] = '0; end
            acc_pend = 0; stall_prev = 0; full_prev = 0; full_left = 0;
            i_mem_waitrequest = 1'b0; i_mem_readdatavalid = 1'b0; i_mem_readdata = '0;
            i_fifo_wrfull = '0; i_fifo_rdempty = '1;
        end else begin
            for (int j = 0; j <= ROWS; j++) empty_now[j] = (fq[j].size() == 0) || force_empty[j];
            if (i_start && !o_busy) begin
                b_vals.delete();
                b_first = -1; done_cnt = 0; stall_used = 0; full_fired = 0;
                for (int i = 0; i < ROWS; i++) begin en_cnt[i] = 0; first_en[i] = -1; last_en[i] = -1; end
                for (int j = 0; j <= ROWS; j++) begin wr_cnt[j] = 0; rd_cnt[j] = 0; end
            end
            if (o_done) done_cnt++;
            if (o_fifo_wrreq != '0) begin
                chk("wr_onehot", 64'($countones(o_fifo_wrreq)), 64'd1);
                if (full_prev) chk("wr_while_full", 64'(o_fifo_wrreq[2]), 64'd0);
                if (exp_wr.size() == 0) chk("wr_unexpected", 64'(idx_of(o_fifo_wrreq)), 64'hFF);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_idx", 64'(idx_of(o_fifo_wrreq)), 64'(e[15:8]));
                    chk("wr_data", 64'(o_fifo_wdata), 64'(e[7:0]));
                end
                for (int j = 0; j <= ROWS; j++)
                    if (o_fifo_wrreq[j]) begin fq[j].push_back(o_fifo_wdata); wr_cnt[j]++; end
            end
            if (o_mac_clr) for (int i = 0; i < ROWS; i++) acc[i] = 0;
            // MAC i consumes the A element read last cycle with the B element of matching position.
            for (int i = 0; i < ROWS; i++) if (o_mac_en[i]) begin
                if (en_cnt[i] < b_vals.size()) acc[i] += int'(rd_data[i]) * b_vals[en_cnt[i]];
                if (en_cnt[i] == 0) first_en[i] = gcyc;
                last_en[i] = gcyc;
                en_cnt[i]++;
            end
            for (int j = 0; j <= ROWS; j++) if (o_fifo_rdreq[j]) begin
                rd_cnt[j]++;
                if (j == ROWS && b_first < 0) b_first = gcyc;
                if (fq[j].size() > 0) rd_data[j] = fq[j].pop_front();
                if (j == ROWS) b_vals.push_back(int'(rd_data[j]));
            end
            i_mem_readdatavalid = acc_pend;
            if (acc_pend) begin
                mem_word       = 64'h0807060504030201;
                i_mem_readdata = mem_word;
                for (int b = 0; b < COLS; b++)
                    exp_wr.push_back({8'(acc_addr - cur_base), mem_word[8*b +: 8]});
            end
            if (stall_prev) begin
                chk("stall_hold_read", 64'(o_mem_read), 64'd1);
                chk("stall_hold_addr", 64'(o_mem_addr), 64'(stall_addr));
            end
            i_mem_waitrequest = o_mem_read && (o_mem_addr == stall_addr) && (stall_used < stall_n);
            if (i_mem_waitrequest) stall_used++;
            stall_prev = i_mem_waitrequest;
            acc_pend   = o_mem_read && !i_mem_waitrequest;
            acc_addr   = o_mem_addr;
            if (full_en && !full_fired && wr_cnt[2] == 3) begin full_left = 3; full_fired = 1; end
            i_fifo_wrfull    = '0;
            i_fifo_wrfull[2] = (full_left > 0);
            full_prev        = (full_left > 0);
            if (full_left > 0) full_left--;
            i_fifo_rdempty = empty_now;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_done"}, 64'(o_done), 64'd0);
        chk({tag, "_err"}, 64'(o_err), 64'd0);
        chk({tag, "_mem_read"}, 64'(o_mem_read), 64'd0);
        chk({tag, "_mem_addr"}, 64'(o_mem_addr), 64'd0);
        chk({tag, "_wrreq"}, 64'(o_fifo_wrreq), 64'd0);
        chk({tag, "_wdata"}, 64'(o_fifo_wdata), 64'd0);
        chk({tag, "_rdreq"}, 64'(o_fifo_rdreq), 64'd0);
        chk({tag, "_mac_clr"}, 64'(o_mac_clr), 64'd0);
        chk({tag, "_mac_en"}, 64'(o_mac_en), 64'd0);
    endtask

    task automatic start_job(input logic [ADDR_W-1:0] base);
        cur_base    = base;
        i_base_addr = base;
        i_start     = 1'b1;
        @(posedge clk); #1;
        i_start     = 1'b0;
        i_base_addr = '0;
        chk("busy_rise", 64'(o_busy), 64'd1);
        chk("first_addr", 64'(o_mem_addr), 64'(base));
        chk("first_read", 64'(o_mem_read), 64'd1);
    endtask

    task automatic wait_exec(output int n);
        n = 0;
        while (!o_fifo_rdreq[ROWS] && n < 400) begin @(posedge clk); #1; n++; end
        chk("exec_reached", 64'(o_fifo_rdreq[ROWS]), 64'd1);
    endtask

    task automatic run_job(input logic [ADDR_W-1:0] base, input bit mid, input int exp_cyc,
                           input int exp_perf);
        int                cyc;
        logic [ADDR_W-1:0] a;
        start_job(base);
        cyc = 1;
        while (!o_done && cyc < 400) begin
            if (mid && cyc == 15) begin
                a = o_mem_addr; i_start = 1'b1; i_base_addr = 32'h500;
                @(posedge clk); #1; cyc++;
                i_start = 1'b0; i_base_addr = '0;
                chk("start_ignored_addr", 64'(o_mem_addr), 64'(a));
                chk("start_ignored_busy", 64'(o_busy), 64'd1);
            end else begin
                @(posedge clk); #1; cyc++;
            end
        end
        chk("done_cycle", 64'(cyc), 64'(exp_cyc));
        @(posedge clk); #1;
        chk("done_pulse", 64'(o_done), 64'd0);
        chk("idle_busy", 64'(o_busy), 64'd0);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("err_clear", 64'(o_err), 64'd0);
        chk("sb_empty", 64'(exp_wr.size()), 64'd0);
        for (int i = 0; i < ROWS; i++) begin
            chk($sformatf("mac%0d_result", i), 64'(acc[i]), 64'd204);
            chk($sformatf("mac%0d_en_cnt", i), 64'(en_cnt[i]), 64'(COLS));
            chk($sformatf("mac%0d_en_start", i), 64'(first_en[i] - b_first), 64'(i + 1));
            chk($sformatf("mac%0d_en_contig", i), 64'(last_en[i] - first_en[i]), 64'(COLS - 1));
        end
        for (int j = 0; j <= ROWS; j++) begin
            chk($sformatf("fifo%0d_writes", j), 64'(wr_cnt[j]), 64'(COLS));
            chk($sformatf("fifo%0d_reads", j), 64'(rd_cnt[j]), 64'(COLS));
        end
`ifdef MATMUL_SEQ_CTRL_PERF_EN
        chk("perf_cycles", 64'(o_perf_cycles), 64'(exp_perf));
`else
        if (exp_perf < 0) chk("perf_arg", 64'(exp_perf), 64'd0);
`endif
    endtask

    initial begin
        int n;
        i_rst_n = 1'b1; i_start = 1'b0; i_base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        i_rst_n = 1'b0;
        @(posedge clk); #1;

        run_job(32'h100, 1'b1, 108, 107);

        stall_addr = 32'h103; stall_n = 5;
        run_job(32'h100, 1'b0, 113, 112);
        stall_addr = '1; stall_n = 0;

        full_en = 1'b1;
        run_job(32'h100, 1'b0, 111, 110);
        full_en = 1'b0;

        // Underrun on row FIFO 5 at stagger step 7
        start_job(32'h100);
        wait_exec(n);
        chk("rdreq_t0", 64'(o_fifo_rdreq), 64'h101);
        repeat (7) @(posedge clk);
        #1;
        chk("rdreq_t7", 64'(o_fifo_rdreq), 64'h1FF);
        force_empty = 9'h020;
        @(posedge clk); #1;
        force_empty = '0;
        chk("underrun_err", 64'(o_err), 64'd1);
        chk("underrun_rdreq", 64'(o_fifo_rdreq), 64'd0);
        chk("underrun_mac_en", 64'(o_mac_en), 64'd0);
        chk("underrun_busy", 64'(o_busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", 64'(o_err), 64'd1);
        chk("underrun_no_done", 64'(done_cnt), 64'd0);
        i_start = 1'b1; i_base_addr = 32'h100;
        @(posedge clk); #1;
        i_start = 1'b0; i_base_addr = '0;
        chk("restart_err_clear", 64'(o_err), 64'd0);
        chk("restart_busy", 64'(o_busy), 64'd1);
        i_rst_n = 1'b1;
        @(posedge clk); #1;
        i_rst_n = 1'b0;
        chk("abort_busy", 64'(o_busy), 64'd0);

        // Reset at stagger step 4
        start_job(32'h100);
        wait_exec(n);
        repeat (4) @(posedge clk);
        #1;
        chk("rdreq_t4", 64'(o_fifo_rdreq), 64'h11F);
        i_rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("midexec_reset");
        i_rst_n = 1'b0;
        @(posedge clk); #1;

        run_job(32'h100, 1'b0, 108, 107);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
